// File: rtl/parity_pkg.sv
// Shared types and default sizes for the parity serializer datapath.
package parity_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEF_WIDTH     = 4;
  localparam int DEF_CNT_WIDTH = 8;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter
  import parity_pkg::*;
#(
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 inc,
  input  logic                 clr,
  output logic [CNT_WIDTH-1:0] count
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs as they were before the edge, independent of order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != CNT_MAX)) begin
      count <= count + CNT_ONE;
    end
  end

endmodule

// File: rtl/parity_serializer.sv
// Captures a word, shifts it out LSB-first, reports its XOR parity and
// keeps a saturating count of odd-parity words.
module parity_serializer
  import parity_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     data_in,
  input  logic                 load,
  input  logic                 clear_count,
  output logic                 busy,
  output logic                 serial_out,
  output logic                 serial_valid,
  output logic                 parity_out,
  output logic                 done,
  output logic [CNT_WIDTH-1:0] odd_count
);

  localparam int                BIT_CW   = $clog2(WIDTH + 1);
  localparam logic [BIT_CW-1:0] LAST_BIT = BIT_CW'(WIDTH - 1);
  localparam logic [BIT_CW-1:0] BIT_ONE  = BIT_CW'(1);

  state_t              state;
  logic [WIDTH-1:0]    shreg;
  logic [BIT_CW-1:0]   bit_cnt;
  logic                par_acc;
  logic                count_inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      par_acc    <= 1'b0;
      parity_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            shreg   <= data_in;
            bit_cnt <= '0;
            par_acc <= 1'b0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          par_acc <= par_acc ^ shreg[0];
          shreg   <= shreg >> 1;
          bit_cnt <= bit_cnt + BIT_ONE;
          // The final bit folds straight into parity_out so it is valid in DONE.
          if (bit_cnt == LAST_BIT) begin
            state      <= DONE;
            parity_out <= par_acc ^ shreg[0];
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // NOTE: every output of this always_comb gets a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    busy         = 1'b0;
    serial_out   = 1'b0;
    serial_valid = 1'b0;
    done         = 1'b0;
    case (state)
      SHIFT: begin
        busy         = 1'b1;
        serial_valid = 1'b1;
        serial_out   = shreg[0];
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // The count advances on the edge leaving DONE, using the parity just latched.
  assign count_inc = (state == DONE) && parity_out;

  sat_counter #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_odd_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (count_inc),
    .clr   (clear_count),
    .count (odd_count)
  );

endmodule
